// File: rtl/sr_latch_driver_pkg.sv
// sr_latch_driver_pkg: op encodings, FSM states and default window lengths for sr_latch_driver.
package sr_latch_driver_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_SET = 2'b01, OP_RESET = 2'b10, OP_ILL = 2'b11} op_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_CHECK} state_t;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC = 1;
  localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if: command handshake plus latch drive/sense; master is the driver, slave is its environment.
interface sr_latch_driver_if;
  import sr_latch_driver_pkg::*;
  logic cmd_valid;
  op_t cmd_op;
  logic cmd_ready;
  logic s;
  logic r;
  logic en;
  logic q;
  logic qn;
  logic done;
  logic err;
  logic q_seen;
  modport master (input cmd_valid, cmd_op, q, qn, output cmd_ready, s, r, en, done, err, q_seen);
  modport slave (output cmd_valid, cmd_op, q, qn, input cmd_ready, s, r, en, done, err, q_seen);
endinterface

// File: rtl/sr_latch_driver_timer.sv
// sr_latch_driver_timer: loadable down-counter that stops at zero, shared by the setup/pulse/hold windows.
module sr_latch_driver_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences s/r/en of a gated SR latch from one command; define SR_LATCH_DRIVER_CHECK_EN to
// have CHECK compare q/qn against the commanded value.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  sr_latch_driver_if.master bus
);
`ifdef SR_LATCH_DRIVER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] SETUP_L = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_L = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_L = CNT_W'(HOLD_CYC - 1);
  state_t state, state_n;
  op_t op_q, op_n;
  logic accept, zero, load, drive_n, chk_fail;
  logic [CNT_W-1:0] load_val;
  assign bus.cmd_ready = !rst && state == ST_IDLE;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  always_comb begin
    op_n = accept ? bus.cmd_op : op_q;
    state_n = state == ST_IDLE ? (accept ? ((op_n == OP_SET || op_n == OP_RESET) ? ST_SETUP : ST_CHECK) : ST_IDLE)
            : state == ST_CHECK ? ST_IDLE
            : !zero ? state
            : state == ST_SETUP ? ST_PULSE
            : state == ST_PULSE ? ST_HOLD : ST_CHECK;
    load = state_n != state;
    load_val = state_n == ST_SETUP ? SETUP_L : state_n == ST_PULSE ? PULSE_L : HOLD_L;
    drive_n = state_n == ST_SETUP || state_n == ST_PULSE || state_n == ST_HOLD;
    chk_fail = CHECK_EN && ((op_q == OP_SET && !(bus.q && !bus.qn)) || (op_q == OP_RESET && !(!bus.q && bus.qn)));
  end
  // s/r/en are registered from the next state so the latch never sees decode glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q <= OP_NOP;
      bus.s <= 1'b0;
      bus.r <= 1'b0;
      bus.en <= 1'b0;
      bus.q_seen <= 1'b0;
    end else begin
      state <= state_n;
      op_q <= op_n;
      bus.s <= drive_n && op_n == OP_SET;
      bus.r <= drive_n && op_n == OP_RESET;
      bus.en <= state_n == ST_PULSE;
      if (state == ST_CHECK) bus.q_seen <= bus.q;
    end
  end
  assign bus.done = state == ST_CHECK;
  assign bus.err = bus.done && (op_q == OP_ILL || chk_fail);
  sr_latch_driver_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value(load_val),
    .zero(zero)
  );
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed bench; one default instance driving a latch model, one PULSE_CYC=3 instance with q stuck at 1.
module tb_sr_latch_driver;
  import sr_latch_driver_pkg::*;
`ifdef SR_LATCH_DRIVER_CHECK_EN
  localparam logic EXP_ERR3 = 1'b1;
`else
  localparam logic EXP_ERR3 = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lq = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sr_latch_driver_if a();
  sr_latch_driver_if b();
  sr_latch_driver dut (.clk(clk), .rst(rst), .bus(a));
  sr_latch_driver #(.PULSE_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(b));
  always @(a.en or a.s or a.r) if (a.en) begin
    if (a.s) lq = 1'b1;
    else if (a.r) lq = 1'b0;
  end
  assign a.q = lq;
  assign a.qn = ~lq;
  assign b.q = 1'b1;
  assign b.qn = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_seq(input string tag);
    logic [5:0] e_en, e_s, e_done, e_rdy;
    e_en = 6'b000110;
    e_s = 6'b001111;
    e_done = 6'b010000;
    e_rdy = 6'b100000;
    a.cmd_op = OP_SET;
    a.cmd_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) a.cmd_valid = 1'b0;
      chk($sformatf("%s_en_c%0d", tag, k), a.en, e_en[k-1]);
      chk($sformatf("%s_s_c%0d", tag, k), a.s, e_s[k-1]);
      chk($sformatf("%s_r_c%0d", tag, k), a.r, 1'b0);
      chk($sformatf("%s_done_c%0d", tag, k), a.done, e_done[k-1]);
      chk($sformatf("%s_rdy_c%0d", tag, k), a.cmd_ready, e_rdy[k-1]);
      if (k == 5) chk($sformatf("%s_err", tag), a.err, 1'b0);
    end
    chk($sformatf("%s_q_seen", tag), a.q_seen, 1'b1);
  endtask

  initial begin
    logic [6:0] e3_en, e3_r, e3_done, e3_rdy;
    int accepts, dones;
    a.cmd_valid = 1'b1;
    a.cmd_op = OP_SET;
    b.cmd_valid = 1'b0;
    b.cmd_op = OP_NOP;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_s", a.s, 1'b0);
      chk("rst_r", a.r, 1'b0);
      chk("rst_en", a.en, 1'b0);
      chk("rst_rdy", a.cmd_ready, 1'b0);
      chk("rst_done", a.done, 1'b0);
    end
    rst = 1'b0;
    a.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rel_rdy", a.cmd_ready, 1'b1);
    chk("rel_done", a.done, 1'b0);
    chk("rel_q_seen", a.q_seen, 1'b0);
    set_seq("set1");
    a.cmd_op = OP_ILL;
    a.cmd_valid = 1'b1;
    @(negedge clk);
    chk("ill_done", a.done, 1'b1);
    chk("ill_err", a.err, 1'b1);
    chk("ill_en", a.en, 1'b0);
    chk("ill_s", a.s, 1'b0);
    chk("ill_r", a.r, 1'b0);
    chk("ill_rdy", a.cmd_ready, 1'b0);
    a.cmd_op = OP_NOP;
    @(negedge clk);
    chk("nop_rdy", a.cmd_ready, 1'b1);
    chk("nop_idle_done", a.done, 1'b0);
    @(negedge clk);
    a.cmd_valid = 1'b0;
    chk("nop_done", a.done, 1'b1);
    chk("nop_err", a.err, 1'b0);
    chk("nop_en", a.en, 1'b0);
    @(negedge clk);
    chk("nop_after_done", a.done, 1'b0);
    chk("nop_after_rdy", a.cmd_ready, 1'b1);
    e3_en = 7'b0001110;
    e3_r = 7'b0011111;
    e3_done = 7'b0100000;
    e3_rdy = 7'b1000000;
    b.cmd_op = OP_RESET;
    b.cmd_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) b.cmd_valid = 1'b0;
      chk($sformatf("rst3_en_c%0d", k), b.en, e3_en[k-1]);
      chk($sformatf("rst3_r_c%0d", k), b.r, e3_r[k-1]);
      chk($sformatf("rst3_s_c%0d", k), b.s, 1'b0);
      chk($sformatf("rst3_done_c%0d", k), b.done, e3_done[k-1]);
      chk($sformatf("rst3_rdy_c%0d", k), b.cmd_ready, e3_rdy[k-1]);
      if (k == 6) chk("rst3_err", b.err, EXP_ERR3);
    end
    chk("rst3_q_seen", b.q_seen, 1'b1);
    a.cmd_op = OP_SET;
    a.cmd_valid = 1'b1;
    @(negedge clk);
    a.cmd_valid = 1'b0;
    chk("abort_s_c1", a.s, 1'b1);
    @(negedge clk);
    chk("abort_en_c2", a.en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_en", a.en, 1'b0);
    chk("abort_s", a.s, 1'b0);
    chk("abort_done", a.done, 1'b0);
    chk("abort_q_seen", a.q_seen, 1'b0);
    chk("abort_rdy", a.cmd_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_done", a.done, 1'b0);
    chk("abort_idle_rdy", a.cmd_ready, 1'b1);
    set_seq("set2");
    accepts = 0;
    dones = 0;
    a.cmd_op = OP_SET;
    a.cmd_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("hold_sr_c%0d", k), a.s & a.r, 1'b0);
      chk($sformatf("hold_en_c%0d", k), a.en, (k % 6 == 2) || (k % 6 == 3));
      chk($sformatf("hold_rdy_done_c%0d", k), a.done & a.cmd_ready, 1'b0);
      if (a.cmd_ready) accepts++;
      if (a.done) dones++;
      @(negedge clk);
    end
    a.cmd_valid = 1'b0;
    chk("hold_accepts", 8'(accepts), 8'd2);
    chk("hold_dones", 8'(dones), 8'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
